// File: rtl/balance_seq_pkg.sv
// Shared types and width constants for the balance sequencer.
package balance_pkg;

  localparam int unsigned PTCH_W = 16;
  localparam int unsigned LD_W   = 12;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    WAIT_SNS = 3'd1,
    RAMP     = 3'd2,
    RUN      = 3'd3,
    FAULT    = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_TILT = 2'd1,
    FLT_WDOG = 2'd2
  } fault_code_t;

endpackage

// File: rtl/balance_seq_sample_debounce.sv
// sample_debounce: counts consecutive enabled samples on which cond holds.
// reach pulses combinationally on the sample that brings the count to N.
// SAT=1 holds the count at N afterwards; SAT=0 restarts it from zero.
module sample_debounce #(
  parameter int unsigned N   = 4,
  parameter bit          SAT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic cond,
  output logic reach
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and reach detection
  always_comb begin
    cnt_d = cnt_q;
    reach = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cond) begin
        if (cnt_q >= CW'(N - 1)) begin
          reach = 1'b1;
          cnt_d = SAT ? CW'(N) : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/balance_seq.sv
// balance_seq: power-up / soft-start sequencer for the PID block, with
// rider-presence debounce and tilt fault. Optional watchdog enabled by
// defining BALANCE_SEQ_WDOG_EN.
module balance_seq
  import balance_pkg::*;
#(
  parameter logic        [LD_W-1:0]   MIN_RIDER_WT = 12'h200,
  parameter logic        [LD_W-1:0]   WT_HYST      = 12'h040,
  parameter int unsigned              RIDER_DB     = 4,
  parameter logic signed [PTCH_W-1:0] PTCH_LIMIT   = 16'sd1600,
  parameter int unsigned              TILT_CNT     = 8,
  parameter logic        [19:0]       WDOG_CYC     = 20'd1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwr_btn,
  input  logic                     nemo_setup,
  input  logic                     smpl_vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic        [LD_W-1:0]   lft_ld,
  input  logic        [LD_W-1:0]   rght_ld,
  input  logic        [7:0]        ss_tmr,
  output logic                     pid_vld,
  output logic                     pwr_up,
  output logic                     rider_off,
  output logic                     en_steer,
  output logic                     fault,
  output logic        [1:0]        fault_code,
  output logic        [2:0]        seq_state
);

  seq_state_t  state_q, state_d;
  fault_code_t fault_code_q, fault_code_d;
  logic        btn_q;
  logic        pid_vld_q, pid_vld_d;
  logic        rider_off_q, rider_off_d;
  logic        en_steer_q, en_steer_d;

  logic            btn_rise;
  logic            active;
  logic            ramp_entry;
  logic [LD_W:0]   ld_sum;
  logic            rider_cond;
  logic            rider_reach;
  logic [PTCH_W-1:0] ptch_mag;
  logic            over_tilt;
  logic            tilt_trip;
  logic            wdog_hit;

  assign btn_rise   = pwr_btn & ~btn_q;
  assign active     = (state_q == RAMP) || (state_q == RUN);
  assign ramp_entry = (state_d == RAMP) && (state_q != RAMP);

  // Rider qualification with hysteresis around the threshold
  always_comb begin
    ld_sum = {1'b0, lft_ld} + {1'b0, rght_ld};
    if (rider_off_q) rider_cond = (ld_sum >= {1'b0, MIN_RIDER_WT});
    else             rider_cond = (ld_sum < {1'b0, MIN_RIDER_WT - WT_HYST});
  end

  // Pitch magnitude as unsigned so 16'h8000 maps to 32768 (over-limit)
  always_comb begin
    ptch_mag  = ptch[PTCH_W-1] ? (~ptch + 1'b1) : ptch;
    over_tilt = (ptch_mag > $unsigned(PTCH_LIMIT));
  end

  sample_debounce #(.N(RIDER_DB), .SAT(1'b0)) u_rider_db (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_q == OFF) || (state_q == WAIT_SNS)),
    .en    (smpl_vld),
    .cond  (rider_cond),
    .reach (rider_reach)
  );

  sample_debounce #(.N(TILT_CNT), .SAT(1'b1)) u_tilt_db (
    .clk   (clk),
    .rst   (rst),
    .clr   (ramp_entry),
    .en    (smpl_vld & active),
    .cond  (over_tilt),
    .reach (tilt_trip)
  );

`ifdef BALANCE_SEQ_WDOG_EN
  logic [19:0] wdog_q, wdog_d;

  // Clocks since the last sample while ramping or running
  always_comb begin
    wdog_d   = '0;
    wdog_hit = active && (wdog_q == WDOG_CYC - 20'd1);
    if (!(smpl_vld || ramp_entry) && active) wdog_d = wdog_q + 20'd1;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= OFF;
    else     state_q <= state_d;
  end

  // Next-state logic; a button edge outranks any fault trip
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF: if (btn_rise) state_d = WAIT_SNS;
      WAIT_SNS: begin
        if (btn_rise)        state_d = OFF;
        else if (nemo_setup) state_d = RAMP;
      end
      RAMP: begin
        if (btn_rise)                  state_d = OFF;
        else if (tilt_trip | wdog_hit) state_d = FAULT;
        else if (ss_tmr == 8'hFF)      state_d = RUN;
      end
      RUN: begin
        if (btn_rise)                  state_d = OFF;
        else if (tilt_trip | wdog_hit) state_d = FAULT;
      end
      FAULT: if (btn_rise) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pwr_up = active;
    fault  = (state_q == FAULT);
  end

  // Datapath next values: fault code, pid strobe, rider state, steering
  always_comb begin
    fault_code_d = fault_code_q;
    if (btn_rise && state_q != OFF) begin
      fault_code_d = FLT_NONE;
    end else if (active && fault_code_q == FLT_NONE) begin
      if (tilt_trip)     fault_code_d = FLT_TILT;
      else if (wdog_hit) fault_code_d = FLT_WDOG;
    end

    pid_vld_d = smpl_vld & active & ~pid_vld_q;

    rider_off_d = rider_off_q;
    if ((state_q == OFF) || (state_q == WAIT_SNS)) rider_off_d = 1'b1;
    else if (rider_reach)                          rider_off_d = ~rider_off_q;

    en_steer_d = (state_q == RUN) & ~rider_off_q;
  end

  // Datapath registers; button copy resets high so a held button is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q        <= 1'b1;
      fault_code_q <= FLT_NONE;
      pid_vld_q    <= 1'b0;
      rider_off_q  <= 1'b1;
      en_steer_q   <= 1'b0;
    end else begin
      btn_q        <= pwr_btn;
      fault_code_q <= fault_code_d;
      pid_vld_q    <= pid_vld_d;
      rider_off_q  <= rider_off_d;
      en_steer_q   <= en_steer_d;
    end
  end

  assign pid_vld    = pid_vld_q;
  assign rider_off  = rider_off_q;
  assign en_steer   = en_steer_q;
  assign fault_code = fault_code_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_balance_seq.sv
// Directed bench for balance_seq; watchdog checks follow BALANCE_SEQ_WDOG_EN.
module tb_balance_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               pwr_btn;
  logic               nemo_setup;
  logic               smpl_vld;
  logic signed [15:0] ptch;
  logic        [11:0] lft_ld;
  logic        [11:0] rght_ld;
  logic        [7:0]  ss_tmr;
  logic               pid_vld;
  logic               pwr_up;
  logic               rider_off;
  logic               en_steer;
  logic               fault;
  logic        [1:0]  fault_code;
  logic        [2:0]  seq_state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  balance_seq #(.WDOG_CYC(20'd100)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_btn    (pwr_btn),
    .nemo_setup (nemo_setup),
    .smpl_vld   (smpl_vld),
    .ptch       (ptch),
    .lft_ld     (lft_ld),
    .rght_ld    (rght_ld),
    .ss_tmr     (ss_tmr),
    .pid_vld    (pid_vld),
    .pwr_up     (pwr_up),
    .rider_off  (rider_off),
    .en_steer   (en_steer),
    .fault      (fault),
    .fault_code (fault_code),
    .seq_state  (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // One sample: present it for a single clock, leave the bench just after that edge
  task automatic pulse(input logic signed [15:0] p, input logic [11:0] l, input logic [11:0] r);
    ptch = p; lft_ld = l; rght_ld = r; smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(seq_state), 32'd0);
    chk({tag, "_pidvld"}, 32'(pid_vld), 32'd0);
    chk({tag, "_pwrup"}, 32'(pwr_up), 32'd0);
    chk({tag, "_rideroff"}, 32'(rider_off), 32'd1);
    chk({tag, "_ensteer"}, 32'(en_steer), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_fcode"}, 32'(fault_code), 32'd0);
  endtask

  initial begin
    int unsigned waited;
    rst = 1'b1; pwr_btn = 1'b0; nemo_setup = 1'b0; smpl_vld = 1'b0;
    ptch = '0; lft_ld = '0; rght_ld = '0; ss_tmr = '0;
    idle(2);
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // 1/4: power-up, pid_vld gating in WAIT_SNS vs RAMP
    pwr_btn = 1'b1; tick(); pwr_btn = 1'b0;
    chk("pu_wait", 32'(seq_state), 32'd1);
    idle(4);
    pulse(16'sd0, 12'h0, 12'h0);
    chk("wait_pidvld", 32'(pid_vld), 32'd0);
    idle(5);
    chk("wait_hold", 32'(seq_state), 32'd1);
    chk("wait_pwrup", 32'(pwr_up), 32'd0);
    nemo_setup = 1'b1; tick();
    chk("pu_ramp", 32'(seq_state), 32'd2);
    chk("ramp_pwrup", 32'(pwr_up), 32'd1);
    pulse(16'sd0, 12'h0, 12'h0);
    chk("ramp_pidvld", 32'(pid_vld), 32'd1);
    tick();
    chk("ramp_pidvld_off", 32'(pid_vld), 32'd0);
    for (int unsigned v = 8'hF0; v < 8'hFF; v++) begin
      ss_tmr = 8'(v); tick();
    end
    chk("ramp_hold", 32'(seq_state), 32'd2);
    ss_tmr = 8'hFF; tick();
    chk("pu_run", 32'(seq_state), 32'd3);

    // 2: rider debounce with hysteresis
    for (int unsigned i = 0; i < 3; i++) begin pulse(16'sd0, 12'h100, 12'h100); idle(3); end
    chk("rider_3", 32'(rider_off), 32'd1);
    pulse(16'sd0, 12'h100, 12'h100);
    chk("rider_on", 32'(rider_off), 32'd0);
    chk("steer_lag", 32'(en_steer), 32'd0);
    tick();
    chk("steer_on", 32'(en_steer), 32'd1);
    idle(2);
    for (int unsigned i = 0; i < 10; i++) begin pulse(16'sd0, 12'h0E8, 12'h0E8); idle(3); end
    chk("rider_band", 32'(rider_off), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin pulse(16'sd0, 12'h080, 12'h080); idle(3); end
    chk("rider_off_3", 32'(rider_off), 32'd0);
    pulse(16'sd0, 12'h080, 12'h080);
    chk("rider_off", 32'(rider_off), 32'd1);
    tick();
    chk("steer_off", 32'(en_steer), 32'd0);
    idle(2);

    // 3: tilt trip
    for (int unsigned i = 0; i < 7; i++) begin pulse(16'sd1601, 12'h0, 12'h0); idle(3); end
    chk("tilt_7", 32'(seq_state), 32'd3);
    pulse(16'sd0, 12'h0, 12'h0); idle(3);
    for (int unsigned i = 0; i < 7; i++) begin pulse(-16'sd1700, 12'h0, 12'h0); idle(3); end
    chk("tilt_neg7", 32'(seq_state), 32'd3);
    pulse(-16'sd1700, 12'h0, 12'h0);
    chk("tilt_fault", 32'(seq_state), 32'd4);
    chk("tilt_faultbit", 32'(fault), 32'd1);
    chk("tilt_code", 32'(fault_code), 32'd1);
    chk("tilt_pwrup", 32'(pwr_up), 32'd0);
    idle(2);
    pulse(16'sd0, 12'h0, 12'h0);
    chk("fault_pidvld", 32'(pid_vld), 32'd0);
    idle(2);

    // 5a: button clears fault, then edge beats simultaneous tilt trip
    pwr_btn = 1'b1; tick(); pwr_btn = 1'b0;
    chk("clr_state", 32'(seq_state), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    tick();
    pwr_btn = 1'b1; tick(); pwr_btn = 1'b0;
    tick(); tick();
    chk("re_run", 32'(seq_state), 32'd3);
    for (int unsigned i = 0; i < 7; i++) begin pulse(16'sh8000, 12'h0, 12'h0); idle(3); end
    pulse(16'sd1600, 12'h0, 12'h0); idle(3);
    chk("limit_exact", 32'(seq_state), 32'd3);
    for (int unsigned i = 0; i < 7; i++) begin pulse(16'sh8000, 12'h0, 12'h0); idle(3); end
    chk("min_neg7", 32'(seq_state), 32'd3);
    pwr_btn = 1'b1;
    pulse(16'sh8000, 12'h0, 12'h0);
    pwr_btn = 1'b0;
    chk("race_state", 32'(seq_state), 32'd0);
    chk("race_fault", 32'(fault), 32'd0);
    chk("race_code", 32'(fault_code), 32'd0);
    tick();

    // 5b: synchronous reset mid-RAMP, button held high through reset
    ss_tmr = 8'h10;
    pwr_btn = 1'b1; tick(); pwr_btn = 1'b0; tick();
    chk("r_ramp", 32'(seq_state), 32'd2);
    pwr_btn = 1'b1; rst = 1'b1; smpl_vld = 1'b1;
    tick();
    smpl_vld = 1'b0;
    chk_reset("midrst");
    rst = 1'b0;
    idle(2);
    chk("held_btn", 32'(seq_state), 32'd0);
    pwr_btn = 1'b0; tick();

    // 6: sample starvation in RUN
    pwr_btn = 1'b1; tick(); pwr_btn = 1'b0; tick();
    ss_tmr = 8'hFF; tick();
    chk("wd_run", 32'(seq_state), 32'd3);
    pulse(16'sd0, 12'h0, 12'h0);
`ifdef BALANCE_SEQ_WDOG_EN
    waited = 0;
    while (seq_state != 3'd4 && waited < 300) begin tick(); waited++; end
    chk("wd_clocks", waited, 32'd100);
    chk("wd_state", 32'(seq_state), 32'd4);
    chk("wd_code", 32'(fault_code), 32'd2);
`else
    waited = 0;
    while (seq_state == 3'd3 && waited < 300) begin tick(); waited++; end
    chk("nowd_clocks", waited, 32'd300);
    chk("nowd_state", 32'(seq_state), 32'd3);
    chk("nowd_code", 32'(fault_code), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/balance_seq.md
Name: balance_seq

Overview:
- Top-level sequencer for the balance datapath.
- Owns power-up and soft-start sequencing of the PID block (drives its pwr_up, rider_off and vld inputs).
- Qualifies inertial samples, debounces rider presence from the load cells, and trips a tilt fault.
- Sits between the inertial interface, the load-cell A2D and the PID/steering blocks.

Parameters:
- MIN_RIDER_WT, 12'h200: rider-present threshold on the summed load.
- WT_HYST, 12'h040: hysteresis; rider is lost when the sum drops below MIN_RIDER_WT-WT_HYST.
- RIDER_DB, 4: consecutive qualifying samples needed to change rider state.
- PTCH_LIMIT, 16'sd1600: magnitude of pitch beyond which a sample counts as over-tilt.
- TILT_CNT, 8: consecutive over-tilt samples that cause a fault.
- WDOG_CYC, 20'd1000000: watchdog timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pwr_btn  in  1  synchronised power button level; toggles on/off on its rising edge
- nemo_setup  in  1  inertial sensor configured
- smpl_vld  in  1  one-cycle pulse: new ptch sample available
- ptch  in  16 signed  current pitch
- lft_ld  in  12  left load cell
- rght_ld  in  12  right load cell
- ss_tmr  in  8  soft-start timer from PID
- pid_vld  out  1  one-cycle strobe to PID integrator
- pwr_up  out  1  PID soft-start enable
- rider_off  out  1  debounced rider absent
- en_steer  out  1  steering enable
- fault  out  1  sticky fault
- fault_code  out  2  0 none, 1 tilt, 2 watchdog
- seq_state  out  3  current FSM state, for debug

Behaviour:
- Reset values:
  - seq_state=OFF.
  - pid_vld=0, pwr_up=0, en_steer=0, fault=0, fault_code=0.
  - rider_off=1.
  - All counters 0.
- Rising edge of pwr_btn: detected with a registered copy. The registered copy resets to 1, so a button held high through reset does not count as an edge.
- FSM states:
  - OFF=0: pwr_up=0. Rising edge -> WAIT_SNS.
  - WAIT_SNS=1: pwr_up=0. nemo_setup=1 -> RAMP.
  - RAMP=2: pwr_up=1. ss_tmr==8'hFF -> RUN.
  - RUN=3: pwr_up=1.
  - FAULT=4: pwr_up=0, fault=1.
- Exits common to the active states:
  - Rising edge in WAIT_SNS, RAMP, RUN or FAULT -> OFF. This clears fault and fault_code.
  - The tilt trip in RAMP or RUN -> FAULT.
  - If the edge and the trip happen in the same cycle, the edge wins (-> OFF).
- pid_vld:
  - Equals smpl_vld registered once (1-cycle latency).
  - Asserted only when the state at the smpl_vld cycle is RAMP or RUN.
  - Never asserted in two consecutive cycles.
- Rider debounce:
  - Evaluated only on smpl_vld.
  - sum = lft_ld + rght_ld, 13-bit unsigned, no overflow.
  - When rider_off=1: sum >= MIN_RIDER_WT increments the debounce count; otherwise the count clears.
  - When rider_off=0: sum < MIN_RIDER_WT-WT_HYST increments the count; otherwise the count clears.
  - Count reaching RIDER_DB toggles rider_off and clears the count.
  - rider_off is forced to 1 and the count cleared in OFF and WAIT_SNS.
- en_steer = (state==RUN) & !rider_off, registered.
- Tilt detect:
  - Evaluated on smpl_vld in RAMP or RUN.
  - |ptch| > PTCH_LIMIT increments tilt_cnt (saturating at TILT_CNT); otherwise tilt_cnt clears.
  - 16'h8000 is treated as over-limit; no negation overflow.
  - tilt_cnt==TILT_CNT -> FAULT with fault_code=1.
  - tilt_cnt clears on entry to RAMP.
- Fault codes are sticky until an OFF transition. A later fault never overwrites the code.

Optional Feature:
- Macro: BALANCE_SEQ_WDOG_EN.
- Defined:
  - A 20-bit counter counts clocks in RAMP and RUN.
  - It clears on smpl_vld and on entry to RAMP.
  - Reaching WDOG_CYC-1 -> FAULT with fault_code=2.
  - If the tilt trip and the watchdog fire in the same cycle, the tilt code wins.
- Undefined:
  - No counter is instantiated.
  - fault_code never equals 2.
  - WDOG_CYC is unused.

Decomposition:
- Package balance_pkg holds:
  - the seq_state_t enum (OFF, WAIT_SNS, RAMP, RUN, FAULT; 3-bit),
  - the fault_code_t enum (FLT_NONE, FLT_TILT, FLT_WDOG),
  - width constants PTCH_W=16 and LD_W=12.
- One sub-module, sample_debounce: a generic N-sample consecutive-condition counter with clear. It is instantiated twice, for rider-on/off and for tilt.

Test Plan:
1. Power-up sequence: rst high 2 clocks, pwr_btn 0->1, nemo_setup=1 after 10 clocks, ss_tmr stepped to 8'hFF -> seq_state goes 0->1->2->3; pwr_up rises on entry to RAMP.
2. Rider debounce in RUN with lft_ld=rght_ld=12'h100 (sum 0x200) on 4 consecutive smpl_vld -> rider_off falls after the 4th and en_steer=1 next clock. Then sum=0x1D0 (inside the hysteresis band) for 10 samples -> no change. Then sum=0x100 for 4 samples -> rider_off=1.
3. Tilt trip in RUN with ptch=16'sd1601 for 7 samples, then 0, then 8 consecutive samples of -16'sd1700 -> no fault after the first burst; FAULT on the 8th of the second burst with fault_code=1, pwr_up=0, pid_vld=0 thereafter.
4. pid_vld check: smpl_vld pulses in WAIT_SNS give pid_vld=0; in RAMP, pid_vld follows each smpl_vld by exactly 1 clock.
5. Simultaneous events: pwr_btn rising edge in the same cycle as the 8th over-tilt sample -> OFF, fault=0. Synchronous rst asserted mid-RAMP -> all outputs at reset values on the next clock.
6. With BALANCE_SEQ_WDOG_EN and WDOG_CYC=100: smpl_vld stops in RUN -> FAULT with fault_code=2 after 100 clocks. Without the macro, the same stimulus stays in RUN.
